// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter driving the select lines of a 4:1 mux,
// with valid/ready gating and a stall watchdog on the current owner.
module mux4_rr_arbiter #(
   parameter int WIDTH   = 1,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic [WIDTH-1:0] I2,
   input  logic [WIDTH-1:0] I3,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] OUT,
   output logic             out_last,
   output logic [3:0]       gnt,
   output logic             SEL1,
   output logic             SEL0,
   output logic             busy,
   output logic             timeout_err
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       terr_q, terr_d;

   logic [1:0] base;
   logic [1:0] cand;
   logic [1:0] pick_idx;
   logic       pick_any;
   logic       own_req;
   logic       xfer;
   logic       rel;
   logic       expire;

   // State register: grant state, select, RR pointer, stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   // RR search: from ptr when idle, from owner+1 on hand-over
   always_comb begin
      base     = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
      pick_any = |req;
      pick_idx = base;
      cand     = base;
      for (int k = 3; k >= 0; k--) begin
         cand = base + 2'(k);
         if (req[cand]) pick_idx = cand;
      end
   end

   // Next-state: grant, release/re-arbitrate, watchdog expiry
   always_comb begin
      own_req = req[sel_q];
      xfer    = own_req & out_ready;
      rel     = xfer & last[sel_q];
      expire  = ~own_req & (cnt_q == TMO_LAST);
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = 8'd0;
      terr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = GRANT;
               sel_d   = pick_idx;
            end
         end
         GRANT: begin
            if (rel || expire) begin
               ptr_d  = sel_q + 2'd1;
               terr_d = expire;
               if (pick_any) sel_d = pick_idx;
               else          state_d = IDLE;
            end else if (!own_req) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: decoded from the registered select and live owner inputs
   always_comb begin
      busy        = (state_q == GRANT);
      gnt         = busy ? (4'b0001 << sel_q) : 4'b0000;
      out_valid   = busy & req[sel_q];
      out_last    = out_valid & last[sel_q];
      SEL1        = sel_q[1];
      SEL0        = sel_q[0];
      timeout_err = terr_q;
      unique case (sel_q)
         2'd0:    OUT = I0;
         2'd1:    OUT = I1;
         2'd2:    OUT = I2;
         default: OUT = I3;
      endcase
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with a beat scoreboard
// checked on every accepted transfer.
module tb_mux4_rr_arbiter;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [7:0] I0, I1, I2, I3;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] OUT;
   logic       out_last;
   logic [3:0] gnt;
   logic       SEL1, SEL0;
   logic       busy;
   logic       timeout_err;

   int    checks = 0;
   int    errors = 0;
   beat_t sb[$];
   logic [7:0] din [4];

   mux4_rr_arbiter #(.WIDTH(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .I0(I0), .I1(I1), .I2(I2), .I3(I3),
      .out_ready(out_ready), .out_valid(out_valid), .OUT(OUT),
      .out_last(out_last), .gnt(gnt), .SEL1(SEL1), .SEL0(SEL0),
      .busy(busy), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int idx, input logic lst);
      beat_t b;
      b.gnt  = 4'b0001 << idx;
      b.data = din[idx];
      b.last = lst;
      sb.push_back(b);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 4'b0; last = 4'b0; out_ready = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // Scoreboard: every accepted beat must match the next expected one
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL beat_unexpected: observed gnt %0h expected none",
                   gnt);
         end
         if (sb.size() != 0) begin
            beat_t e;
            e = sb.pop_front();
            chk("beat_gnt", 32'(gnt), 32'(e.gnt));
            chk("beat_data", 32'(OUT), 32'(e.data));
            chk("beat_last", 32'(out_last), 32'(e.last));
         end
      end
   end

   initial begin
      logic [3:0] g_exp [5];
      logic [1:0] s_exp [5];
      din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;
      I0 = din[0]; I1 = din[1]; I2 = din[2]; I3 = din[3];
      g_exp[0] = 4'b0001; g_exp[1] = 4'b0010; g_exp[2] = 4'b0100;
      g_exp[3] = 4'b1000; g_exp[4] = 4'b0001;
      s_exp[0] = 2'd0; s_exp[1] = 2'd1; s_exp[2] = 2'd2;
      s_exp[3] = 2'd3; s_exp[4] = 2'd0;

      // reset state
      rst_n = 1'b0;
      req = 4'b0; last = 4'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_sel", 32'({SEL1, SEL0}), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_last", 32'(out_last), 0);
      chk("rst_terr", 32'(timeout_err), 0);
      cyc();
      rst_n = 1'b1;

      // single-beat packet, then stall to idle via watchdog
      cyc();
      req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
      push(0, 1'b1);
      @(negedge clk);
      chk("t1_pre_valid", 32'(out_valid), 0);
      chk("t1_pre_busy", 32'(busy), 0);
      cyc();
      @(negedge clk);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_sel", 32'({SEL1, SEL0}), 0);
      chk("t1_valid", 32'(out_valid), 1);
      cyc();
      req = 4'b0000;
      @(negedge clk);
      chk("t1_regnt", 32'(gnt), 32'h1);
      chk("t1_regnt_valid", 32'(out_valid), 0);
      for (int i = 0; i < 15; i++) begin
         cyc();
         @(negedge clk);
         chk("t1_hold_terr", 32'(timeout_err), 0);
         chk("t1_hold_busy", 32'(busy), 1);
      end
      cyc();
      @(negedge clk);
      chk("t1_terr", 32'(timeout_err), 1);
      chk("t1_idle_gnt", 32'(gnt), 0);
      chk("t1_idle_busy", 32'(busy), 0);
      cyc();
      @(negedge clk);
      chk("t1_terr_pulse", 32'(timeout_err), 0);
      chk("t1_sb_empty", 32'(sb.size()), 0);

      // all requesting, one-beat packets: 0,1,2,3,0 back to back
      do_reset();
      req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(int'(s_exp[i]), 1'b1);
      cyc();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_gnt", 32'(gnt), 32'(g_exp[i]));
         chk("t2_sel", 32'({SEL1, SEL0}), 32'(s_exp[i]));
         chk("t2_valid", 32'(out_valid), 1);
         chk("t2_out", 32'(OUT), 32'(din[s_exp[i]]));
         cyc();
      end
      req = 4'b0000;
      chk("t2_sb_empty", 32'(sb.size()), 0);

      // 3-beat packet from 2 with a ready stall, 1 waiting
      do_reset();
      req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
      push(2, 1'b0); push(2, 1'b0); push(2, 1'b1); push(1, 1'b1);
      cyc();
      req = 4'b0110;
      @(negedge clk);
      chk("t3_b1_gnt", 32'(gnt), 32'h4);
      cyc();
      out_ready = 1'b0;
      @(negedge clk);
      chk("t3_stall_gnt", 32'(gnt), 32'h4);
      chk("t3_stall_valid", 32'(out_valid), 1);
      cyc();
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_b2_gnt", 32'(gnt), 32'h4);
      cyc();
      last = 4'b0100;
      @(negedge clk);
      chk("t3_b3_gnt", 32'(gnt), 32'h4);
      chk("t3_b3_last", 32'(out_last), 1);
      cyc();
      req = 4'b0010; last = 4'b0010;
      @(negedge clk);
      chk("t3_next_gnt", 32'(gnt), 32'h2);
      chk("t3_next_sel", 32'({SEL1, SEL0}), 1);
      cyc();
      req = 4'b0000;
      chk("t3_sb_empty", 32'(sb.size()), 0);

      // owner 3 stalls: watchdog hands grant to 0, no beat from 3
      do_reset();
      req = 4'b1000; last = 4'b0000; out_ready = 1'b0;
      cyc();
      req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
      push(0, 1'b1);
      @(negedge clk);
      chk("t4_gnt3", 32'(gnt), 32'h8);
      chk("t4_valid0", 32'(out_valid), 0);
      for (int i = 0; i < 15; i++) begin
         cyc();
         @(negedge clk);
         chk("t4_hold_gnt", 32'(gnt), 32'h8);
         chk("t4_hold_terr", 32'(timeout_err), 0);
      end
      cyc();
      @(negedge clk);
      chk("t4_terr", 32'(timeout_err), 1);
      chk("t4_new_gnt", 32'(gnt), 32'h1);
      chk("t4_new_sel", 32'({SEL1, SEL0}), 0);
      cyc();
      req = 4'b0000;
      @(negedge clk);
      chk("t4_terr_pulse", 32'(timeout_err), 0);
      chk("t4_sb_empty", 32'(sb.size()), 0);

      // asynchronous reset mid-packet, restart from ptr 0
      do_reset();
      req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
      push(1, 1'b0); push(1, 1'b0);
      cyc();
      @(negedge clk);
      chk("t5_gnt", 32'(gnt), 32'h2);
      cyc();
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_gnt", 32'(gnt), 0);
      chk("t5_rst_sel", 32'({SEL1, SEL0}), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_valid", 32'(out_valid), 0);
      out_ready = 1'b0;
      req = 4'b0110;
      sb.delete();
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_post_idle", 32'(busy), 0);
      cyc();
      @(negedge clk);
      chk("t5_post_gnt", 32'(gnt), 32'h2);
      chk("t5_post_sel", 32'({SEL1, SEL0}), 1);
      chk("t5_post_out", 32'(OUT), 32'(din[1]));
      req = 4'b0000;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin packet arbiter that shares one 4:1 multiplexer output channel among four requesters. It drives the mux select lines `SEL1`/`SEL0`, holds each grant until the granted requester's last beat is accepted downstream, and gates the muxed data with a valid/ready handshake. It sits directly in front of the `MUX_4to1` datapath and owns its select inputs. It also includes a stall watchdog that revokes a grant whose owner stops requesting.

## Interface
- `WIDTH`, 1, data width of each input and of `OUT`
- `TIMEOUT`, 16, consecutive cycles with the owner's `req` low before the grant is revoked (2..255)

- `clk`  input  1  single clock, all state on rising edge
- `rst_n`  input  1  asynchronous active-low reset
- `req`  input  4  per-requester request; `req[i]` high = beat available on `Ii`
- `last`  input  4  `last[i]` marks the final beat of requester i's packet
- `I0`..`I3`  input  WIDTH each  requester data
- `out_ready`  input  1  downstream accepts the beat
- `out_valid`  output  1  beat on `OUT` is valid
- `OUT`  output  WIDTH  muxed data, `I[{SEL1,SEL0}]`
- `out_last`  output  1  `last[{SEL1,SEL0}]` while `out_valid`
- `gnt`  output  4  one-hot current grant, 0 when idle
- `SEL1`, `SEL0`  output  1 each  mux select, registered
- `busy`  output  1  a grant is active
- `timeout_err`  output  1  one-cycle pulse on watchdog revocation

## Operation
- Reset values: `gnt`=0, `SEL1`=`SEL0`=0, `busy`=0, `out_valid`=0, `out_last`=0, `timeout_err`=0, RR pointer `ptr`=0, stall counter=0.
- States: IDLE (`busy`=0) and GRANT (`busy`=1).
- RR pick: the first index with `req` high, searching `ptr`, `ptr+1`, … modulo 4.
- IDLE: if any `req` is high, register the pick into `SEL`/`gnt` and go to GRANT. Otherwise stay IDLE; `SEL` holds its last value.
- GRANT:
  - `out_valid` = `req[sel]`.
  - A transfer occurs when `out_valid & out_ready`.
  - A transfer with `last[sel]` releases the grant:
    - `ptr` ← sel+1 (mod 4).
    - The next owner is picked in the same cycle using the updated pointer, considering all `req` bits. The current owner is therefore lowest priority.
    - If a requester is picked, stay in GRANT with the new `SEL`/`gnt` next cycle. If none, go to IDLE and set `gnt` to 0.
  - A transfer without `last` keeps the grant.
- Combinational outputs:
  - `OUT` and `out_last` are combinational from the registered `SEL`.
  - `OUT` is don't-care when `out_valid`=0.
  - `out_last` is 0 when `out_valid`=0.
- Watchdog:
  - In GRANT, the counter increments each cycle with `req[sel]`=0 and clears on any cycle with `req[sel]`=1.
  - When the counter reaches `TIMEOUT`:
    - Pulse `timeout_err` for one cycle.
    - Set `ptr` ← sel+1.
    - Re-arbitrate exactly as on release.
    - Clear the counter.
  - The counter is also cleared on every grant change and in IDLE.
- Non-owner `req`/`last` inputs are ignored until arbitration. A requester may drop `req` mid-packet without losing its grant, up to `TIMEOUT`-1 cycles.
- Reset mid-packet: all state returns to reset values immediately and asynchronously. The packet is abandoned, and after reset release arbitration restarts from `ptr`=0.

## Timing
- Grant latency: `req` seen high in IDLE at edge N → `gnt`/`SEL`/`busy` valid after edge N, so `out_valid` is high in cycle N+1.
- Back-to-back packets: zero bubble cycles between one owner's last beat and the next owner's first beat when the next owner already has `req` high.
- `out_valid` and `OUT` follow the owner's `req` and `Ii` combinationally within a grant. There is no internal data buffering.
- `ptr` updates only on release or timeout, never on a non-last beat.
- Simultaneous last-beat transfer and watchdog expiry cannot occur, because a transfer clears the counter. Release takes effect.
- `timeout_err` is high for exactly the one cycle after the expiry edge.

## Test plan
- Reset, then `req`=4'b0001 with `last[0]`=1 and `out_ready`=1 → `gnt`=0001, `SEL`=00, `out_valid`=1 one cycle after `req`; the beat transfers; then IDLE with `gnt`=0.
- `req`=4'b1111 held, every beat `last`=1, `out_ready`=1 → grant order 0,1,2,3,0 on consecutive cycles, `SEL` = 00,01,10,11,00, with no bubbles.
- Requester 2 sends a 3-beat packet (`last` on beat 3) while requester 1 requests, with `out_ready` toggled 1,0,1,1 → requester 2 keeps the grant through the stall; `gnt` switches to 0010 only after beat 3 transfers.
- Requester 3 granted, drops `req` for 16 cycles, `TIMEOUT`=16 → `timeout_err` pulses once; the grant moves to the requesting index searched from 0; no beat is emitted from requester 3.
- Assert `rst_n`=0 mid-packet from requester 1 → `gnt`, `SEL`, `busy` and `out_valid` go to 0 immediately; after release with `req`=4'b0110, requester 1 wins because `ptr`=0.
- `WIDTH`=8, `I0`..`I3` = 8'hA0, 8'hB1, 8'hC2, 8'hD3, round-robin across all four → `OUT` matches the selected input on every valid cycle.
